vector_arbiter: RTL

VECTOR_ARBITER -- requirements
Module: vector_arbiter

---
 rtl/vector_pkg.sv | 23 ++
 rtl/vector_rr_arb.sv | 22 ++
 rtl/vector_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// Shared types for the vector-display segment arbiter: FSM states, default
// coordinate width and the segment record.
package vector_pkg;

    localparam int COORD_W_DEF = 9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_LAUNCH   = 3'd2,
        ST_WAITBUSY = 3'd3,
        ST_WAITDONE = 3'd4,
        ST_FINISH   = 3'd5
    } vec_state_e;

    typedef struct packed {
        logic signed [COORD_W_DEF-1:0] stax;
        logic signed [COORD_W_DEF-1:0] stay;
        logic signed [COORD_W_DEF-1:0] endx;
        logic signed [COORD_W_DEF-1:0] endy;
    } vec_seg_t;

endpackage

// File: rtl/vector_rr_arb.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module vector_rr_arb (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_gnt;
        end else if (req[1]) begin
            winner = 1'b1;
        end
        grant = 2'b00;
        if (req != 2'b00) begin
            grant[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/vector_arbiter.sv
// Arbitrates scene/overlay segments onto one line engine, inserting blanked
// settle time when the beam must jump, and guarding the engine with a timeout.
module vector_arbiter
    import vector_pkg::*;
#(
    parameter int COORD_W       = COORD_W_DEF,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      req_valid,
    output logic [1:0]                      req_ready,
    input  logic signed [1:0][COORD_W-1:0]  req_stax,
    input  logic signed [1:0][COORD_W-1:0]  req_stay,
    input  logic signed [1:0][COORD_W-1:0]  req_endx,
    input  logic signed [1:0][COORD_W-1:0]  req_endy,
    output logic [1:0]                      seg_done,
    output logic                            go,
    output logic signed [COORD_W-1:0]       stax,
    output logic signed [COORD_W-1:0]       stay,
    output logic signed [COORD_W-1:0]       endx,
    output logic signed [COORD_W-1:0]       endy,
    input  logic                            busy,
    input  logic                            done,
    output logic                            blank,
    output logic                            gnt_id,
    output logic                            err_timeout,
    output logic [2:0]                      state_debug
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TMO_LAST    = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    vec_state_e             state_q, state_d;
    logic [SW-1:0]          settle_q, settle_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   go_q, blank_q, err_q, gnt_q, last_gnt_q, last_end_valid_q;
    logic [1:0]             seg_done_q;
    logic signed [COORD_W-1:0] stax_q, stay_q, endx_q, endy_q, last_x_q, last_y_q;

    logic [1:0] arb_grant;
    logic       arb_winner;
    logic       accept, contiguous, tmo_fire;

    vector_rr_arb u_rr_arb (
        .req      (req_valid),
        .last_gnt (last_gnt_q),
        .grant    (arb_grant),
        .winner   (arb_winner)
    );

    assign accept     = (state_q == ST_IDLE) && (req_valid != 2'b00);
    assign req_ready  = (state_q == ST_IDLE && rst) ? arb_grant : 2'b00;
    assign contiguous = last_end_valid_q
                        && (req_stax[arb_winner] == last_x_q)
                        && (req_stay[arb_winner] == last_y_q);
    // A completion arriving on the last allowed cycle still wins over the timeout.
    assign tmo_fire   = (state_q == ST_WAITBUSY || state_q == ST_WAITDONE)
                        && !done && (tmo_q >= TMO_LAST);

    always_comb begin
        state_d  = state_q;
        settle_d = (state_q == ST_SETTLE) ? settle_q + 1'b1 : '0;
        tmo_d    = (state_q == ST_LAUNCH || state_q == ST_WAITBUSY || state_q == ST_WAITDONE)
                   ? tmo_q + 1'b1 : '0;
        case (state_q)
            ST_IDLE:     if (accept) state_d = (contiguous || SETTLE_CYCLES == 0) ? ST_LAUNCH : ST_SETTLE;
            ST_SETTLE:   if (settle_q == SETTLE_LAST) state_d = ST_LAUNCH;
            ST_LAUNCH:   state_d = ST_WAITBUSY;
            ST_WAITBUSY: begin
                if (done)          state_d = ST_FINISH;
                else if (tmo_fire) state_d = ST_IDLE;
                else if (busy)     state_d = ST_WAITDONE;
            end
            ST_WAITDONE: begin
                if (done)          state_d = ST_FINISH;
                else if (tmo_fire) state_d = ST_IDLE;
            end
            ST_FINISH:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            settle_q         <= '0;
            tmo_q            <= '0;
            go_q             <= 1'b0;
            blank_q          <= 1'b1;
            seg_done_q       <= 2'b00;
            err_q            <= 1'b0;
            gnt_q            <= 1'b0;
            last_gnt_q       <= 1'b1;
            last_end_valid_q <= 1'b0;
            last_x_q         <= '0;
            last_y_q         <= '0;
            stax_q           <= '0;
            stay_q           <= '0;
            endx_q           <= '0;
            endy_q           <= '0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            go_q       <= (state_d == ST_LAUNCH);
            blank_q    <= (state_d == ST_IDLE) || (state_d == ST_SETTLE);
            seg_done_q <= (state_d == ST_FINISH) ? (2'b01 << gnt_q) : 2'b00;
            if (accept) begin
                stax_q     <= req_stax[arb_winner];
                stay_q     <= req_stay[arb_winner];
                endx_q     <= req_endx[arb_winner];
                endy_q     <= req_endy[arb_winner];
                gnt_q      <= arb_winner;
                last_gnt_q <= arb_winner;
            end
            if (state_q == ST_FINISH) begin
                last_x_q         <= endx_q;
                last_y_q         <= endy_q;
                last_end_valid_q <= 1'b1;
            end
            // Beam position is unknown after a hung engine, so force a settle next time.
            if (tmo_fire) begin
                err_q            <= 1'b1;
                last_end_valid_q <= 1'b0;
            end
        end
    end

    assign go          = go_q;
    assign blank       = blank_q;
    assign seg_done    = seg_done_q;
    assign err_timeout = err_q;
    assign gnt_id      = gnt_q;
    assign stax        = stax_q;
    assign stay        = stay_q;
    assign endx        = endx_q;
    assign endy        = endy_q;
    assign state_debug = state_q;

endmodule
